// File: rtl/execute_muldiv_controller_pkg.sv
// Shared decode constants and FSM encoding for the EX-stage multiply/divide controller.
// Funct codes extend the base R-type instruction constants.
package execute_muldiv_controller_pkg;

    localparam logic [5:0] RTYPE_OPCODE = 6'h00;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/execute_muldiv_controller_iter_step.sv
// One unsigned iteration: shift-add for multiply, restoring shift-subtract for divide.
// Multiply keeps {acc,q} as the running product; divide keeps acc=remainder, q=dividend/quotient.
module muldiv_iter_step #(
    parameter int NB = 32
) (
    input  logic          i_is_div,
    input  logic [NB-1:0] i_acc,
    input  logic [NB-1:0] i_q,
    input  logic [NB-1:0] i_operand,
    output logic [NB-1:0] o_acc,
    output logic [NB-1:0] o_q
);

    logic [NB:0] w_sum;
    logic [NB:0] w_shifted;
    logic [NB:0] w_diff;
    logic        w_fits;

    always_comb begin
        w_sum     = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_operand} : '0);
        w_shifted = {i_acc, i_q[NB-1]};
        // Partial remainder is always < 2*divisor, so bit NB of the difference is a clean borrow flag.
        w_diff    = w_shifted - {1'b0, i_operand};
        w_fits    = ~w_diff[NB];
        if (i_is_div) begin
            o_acc = w_fits ? w_diff[NB-1:0] : w_shifted[NB-1:0];
            o_q   = {i_q[NB-2:0], w_fits};
        end else begin
            o_acc = w_sum[NB:1];
            o_q   = {w_sum[0], i_q[NB-1:1]};
        end
    end

endmodule

// File: rtl/execute_muldiv_controller.sv
// EX-stage multiply/divide sequencer owning HI/LO: multi-cycle MULT/DIV, single-cycle MF*/MT*,
// and pipeline stall while an operation is in flight.
module execute_muldiv_controller
    import execute_muldiv_controller_pkg::*;
#(
    parameter int NB        = 32,
    parameter int NB_FCODE  = 6,
    parameter int NB_OPCODE = 6
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_valid,
    input  logic [NB_OPCODE-1:0] i_instruction_op_code,
    input  logic [NB_FCODE-1:0]  i_instruction_funct_code,
    input  logic [NB-1:0]        i_data_a,
    input  logic [NB-1:0]        i_data_b,
    input  logic                 i_flush,
    output logic                 o_stall,
    output logic                 o_busy,
    output logic [NB-1:0]        o_mf_result,
    output logic                 o_mf_valid,
    output logic [NB-1:0]        o_hi,
    output logic [NB-1:0]        o_lo
);

    localparam int NB_CNT = $clog2(NB);

    muldiv_state_t     r_state;
    muldiv_state_t     w_state_next;
    logic [NB_CNT-1:0] r_count;
    logic              r_is_div;
    logic              r_neg_lo;
    logic              r_neg_hi;
    logic              r_div_zero;
    logic [NB-1:0]     r_operand;
    logic [NB-1:0]     r_acc;
    logic [NB-1:0]     r_q;
    logic [NB-1:0]     r_dividend;
    logic [NB-1:0]     r_hi;
    logic [NB-1:0]     r_lo;

    logic w_dec, w_idle, w_accept;
    logic w_is_mult, w_is_multu, w_is_div, w_is_divu;
    logic w_start, w_mfhi, w_mflo, w_mthi, w_mtlo;
    logic w_signed_op, w_div_op;
    logic [NB-1:0] w_abs_a, w_abs_b, w_op_a, w_op_b;
    logic [NB-1:0] w_step_acc, w_step_q;
    logic [2*NB-1:0] w_prod;
    logic [NB-1:0] w_quot, w_rem, w_fix_hi, w_fix_lo;

    always_comb begin
        w_dec      = i_valid && (i_instruction_op_code == NB_OPCODE'(RTYPE_OPCODE));
        w_is_mult  = i_instruction_funct_code == NB_FCODE'(FUNCT_MULT);
        w_is_multu = i_instruction_funct_code == NB_FCODE'(FUNCT_MULTU);
        w_is_div   = i_instruction_funct_code == NB_FCODE'(FUNCT_DIV);
        w_is_divu  = i_instruction_funct_code == NB_FCODE'(FUNCT_DIVU);
        w_start    = w_dec && (w_is_mult || w_is_multu || w_is_div || w_is_divu);
        w_mfhi     = w_dec && (i_instruction_funct_code == NB_FCODE'(FUNCT_MFHI));
        w_mflo     = w_dec && (i_instruction_funct_code == NB_FCODE'(FUNCT_MFLO));
        w_mthi     = w_dec && (i_instruction_funct_code == NB_FCODE'(FUNCT_MTHI));
        w_mtlo     = w_dec && (i_instruction_funct_code == NB_FCODE'(FUNCT_MTLO));
        w_idle     = (r_state == ST_IDLE);
        w_accept   = w_start && w_idle && !i_flush;
        w_signed_op = w_is_mult || w_is_div;
        w_div_op    = w_is_div || w_is_divu;
        w_abs_a    = i_data_a[NB-1] ? -i_data_a : i_data_a;
        w_abs_b    = i_data_b[NB-1] ? -i_data_b : i_data_b;
        w_op_a     = w_signed_op ? w_abs_a : i_data_a;
        w_op_b     = w_signed_op ? w_abs_b : i_data_b;
    end

    muldiv_iter_step #(.NB(NB)) u_step (
        .i_is_div  (r_is_div),
        .i_acc     (r_acc),
        .i_q       (r_q),
        .i_operand (r_operand),
        .o_acc     (w_step_acc),
        .o_q       (w_step_q)
    );

    // Sign fix-up applied to the unsigned magnitudes on the FIX edge.
    always_comb begin
        w_prod = r_neg_lo ? -{r_acc, r_q} : {r_acc, r_q};
        w_quot = r_neg_lo ? -r_q : r_q;
        w_rem  = r_neg_hi ? -r_acc : r_acc;
        if (!r_is_div) begin
            w_fix_hi = w_prod[2*NB-1:NB];
            w_fix_lo = w_prod[NB-1:0];
        end else if (r_div_zero) begin
            w_fix_hi = r_dividend;
            w_fix_lo = '1;
        end else begin
            w_fix_hi = w_rem;
            w_fix_lo = w_quot;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = ST_RUN;
            ST_RUN:  if (r_count == '0) w_state_next = ST_FIX;
            ST_FIX:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
        if (i_flush) w_state_next = ST_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) r_state <= ST_IDLE;
        else            r_state <= w_state_next;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_count    <= '0;
            r_is_div   <= 1'b0;
            r_neg_lo   <= 1'b0;
            r_neg_hi   <= 1'b0;
            r_div_zero <= 1'b0;
            r_operand  <= '0;
            r_acc      <= '0;
            r_q        <= '0;
            r_dividend <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            if (w_accept) begin
                r_count    <= NB_CNT'(NB-1);
                r_is_div   <= w_div_op;
                r_neg_lo   <= w_signed_op && (i_data_a[NB-1] ^ i_data_b[NB-1]);
                r_neg_hi   <= w_signed_op && i_data_a[NB-1];
                r_div_zero <= w_div_op && (i_data_b == '0);
                r_operand  <= w_op_b;
                r_acc      <= '0;
                r_q        <= w_op_a;
                r_dividend <= i_data_a;
            end else if (r_state == ST_RUN) begin
                r_acc   <= w_step_acc;
                r_q     <= w_step_q;
                r_count <= r_count - 1'b1;
            end

            if (r_state == ST_FIX && !i_flush) begin
                r_hi <= w_fix_hi;
                r_lo <= w_fix_lo;
            end else if (w_idle) begin
                if (w_mthi) r_hi <= i_data_a;
                if (w_mtlo) r_lo <= i_data_a;
            end
        end
    end

    always_comb begin
        o_busy      = !w_idle;
        o_stall     = (w_start || w_mfhi || w_mflo || w_mthi || w_mtlo) && !w_idle;
        o_mf_valid  = (w_mfhi || w_mflo) && w_idle;
        o_mf_result = '0;
        if (o_mf_valid) o_mf_result = w_mfhi ? r_hi : r_lo;
        o_hi        = r_hi;
        o_lo        = r_lo;
    end

endmodule

// File: tb/tb_execute_muldiv_controller.sv
// Directed bench for the muldiv controller: vector table for arithmetic results plus
// hand-written sequences for stall, MT/MF forwarding, reset and flush corner cases.
module tb_execute_muldiv_controller;

    localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;

    logic        clk = 1'b0;
    logic        reset_n, valid, flush;
    logic [5:0]  op, funct;
    logic [31:0] a, b;
    logic        stall, busy, mf_valid;
    logic [31:0] mf_result, hi, lo;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    execute_muldiv_controller dut (
        .i_clk                    (clk),
        .i_reset_n                (reset_n),
        .i_valid                  (valid),
        .i_instruction_op_code    (op),
        .i_instruction_funct_code (funct),
        .i_data_a                 (a),
        .i_data_b                 (b),
        .i_flush                  (flush),
        .o_stall                  (stall),
        .o_busy                   (busy),
        .o_mf_result              (mf_result),
        .o_mf_valid               (mf_valid),
        .o_hi                     (hi),
        .o_lo                     (lo)
    );

    typedef struct {
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [5:0] f, input logic [31:0] va, input logic [31:0] vb);
        valid = 1'b1; op = 6'h00; funct = f; a = va; b = vb;
    endtask

    task automatic idle_inputs();
        valid = 1'b0; op = 6'h00; funct = 6'h00; a = '0; b = '0;
    endtask

    // Counts busy cycles after an accepted start; bounded so a stuck FSM still reaches the summary.
    task automatic wait_done(output int n_busy);
        n_busy = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (busy) n_busy++;
            else break;
        end
    endtask

    initial begin
        int n_busy;
        int n_stall;

        vecs[0] = '{F_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1] = '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{F_DIVU,  32'd50,       32'd15,       32'h00000005, 32'h00000003};
        vecs[4] = '{F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5] = '{F_DIVU,  32'h00000009, 32'h00000000, 32'h00000009, 32'hFFFFFFFF};
        vecs[6] = '{F_MULT,  32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006};
        vecs[7] = '{F_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[8] = '{F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[9] = '{F_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};

        reset_n = 1'b0; flush = 1'b0;
        idle_inputs();
        tick(); tick();
        @(negedge clk);
        chk("reset_hi", 64'(hi), 64'h0);
        chk("reset_lo", 64'(lo), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_mf_valid", 64'(mf_valid), 64'h0);
        chk("reset_stall", 64'(stall), 64'h0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            present(vecs[i].funct, vecs[i].a, vecs[i].b);
            @(negedge clk);
            chk("start_no_stall", 64'(stall), 64'h0);
            tick();
            idle_inputs();
            wait_done(n_busy);
            $display("vec %0d funct=%h a=%h b=%h -> hi=%h lo=%h busy=%0d", i, vecs[i].funct,
                     vecs[i].a, vecs[i].b, hi, lo, n_busy);
            chk($sformatf("vec%0d_busy_cycles", i), 64'(n_busy), 64'd33);
            chk($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].exp_hi));
            chk($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].exp_lo));
            tick();
        end

        // MTLO then MFLO forwards the newly written value
        present(F_MTLO, 32'h00001234, 32'h0);
        tick();
        present(F_MFLO, 32'h0, 32'h0);
        @(negedge clk);
        $display("MTLO/MFLO mf_result=%h mf_valid=%b stall=%b", mf_result, mf_valid, stall);
        chk("mflo_result", 64'(mf_result), 64'h00001234);
        chk("mflo_valid", 64'(mf_valid), 64'h1);
        chk("mflo_stall", 64'(stall), 64'h0);
        present(F_MTHI, 32'hCAFE0001, 32'h0);
        tick();
        present(F_MFHI, 32'h0, 32'h0);
        @(negedge clk);
        $display("MTHI/MFHI mf_result=%h", mf_result);
        chk("mfhi_result", 64'(mf_result), 64'hCAFE0001);
        tick();
        idle_inputs();
        @(negedge clk);
        chk("mf_idle_result", 64'(mf_result), 64'h0);
        tick();

        // MULT 5*6 then MFLO one cycle later: stalls for the rest of the operation
        present(F_MULT, 32'd5, 32'd6);
        tick();
        idle_inputs();
        op = 6'h00; funct = 6'h20; valid = 1'b1;
        @(negedge clk);
        chk("nonmuldiv_no_stall", 64'(stall), 64'h0);
        tick();
        present(F_MFLO, 32'h0, 32'h0);
        n_stall = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (stall) n_stall++;
            else break;
            tick();
        end
        $display("MULT 5*6 + MFLO stall=%0d mf_result=%h", n_stall, mf_result);
        chk("mflo_stall_cycles", 64'(n_stall), 64'd32);
        chk("mflo_after_stall", 64'(mf_result), 64'h0000001E);
        chk("mflo_after_valid", 64'(mf_valid), 64'h1);
        chk("mflo_after_stall_low", 64'(stall), 64'h0);
        tick();
        idle_inputs();
        tick();

        // Reset during a DIV at cycle 10
        present(F_DIV, 32'd100, 32'd7);
        tick();
        idle_inputs();
        repeat (9) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        $display("reset mid-DIV busy=%b hi=%h lo=%h", busy, hi, lo);
        chk("rst_mid_busy", 64'(busy), 64'h0);
        chk("rst_mid_hi", 64'(hi), 64'h0);
        chk("rst_mid_lo", 64'(lo), 64'h0);
        tick();

        // Flush at cycle 10 keeps prior HI/LO
        present(F_MTHI, 32'hAAAA0000, 32'h0);
        tick();
        present(F_MTLO, 32'h00005555, 32'h0);
        tick();
        present(F_DIVU, 32'd100, 32'd7);
        tick();
        idle_inputs();
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        $display("flush mid-DIVU busy=%b hi=%h lo=%h", busy, hi, lo);
        chk("flush_mid_busy", 64'(busy), 64'h0);
        chk("flush_mid_hi", 64'(hi), 64'hAAAA0000);
        chk("flush_mid_lo", 64'(lo), 64'h00005555);
        tick();

        // Flush in the FIX cycle wins over the HI/LO write
        present(F_MULTU, 32'd3, 32'd4);
        tick();
        idle_inputs();
        repeat (32) tick();
        @(negedge clk);
        chk("fix_still_busy", 64'(busy), 64'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        $display("flush in FIX busy=%b hi=%h lo=%h", busy, hi, lo);
        chk("flush_fix_busy", 64'(busy), 64'h0);
        chk("flush_fix_hi", 64'(hi), 64'hAAAA0000);
        chk("flush_fix_lo", 64'(lo), 64'h00005555);
        tick();

        // Start presented together with flush is discarded
        present(F_MULT, 32'd2, 32'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle_inputs();
        @(negedge clk);
        $display("start with flush busy=%b", busy);
        chk("start_flush_busy", 64'(busy), 64'h0);
        chk("start_flush_lo", 64'(lo), 64'h00005555);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
